// File: rtl/lidar_result_packer.sv
// lidar_result_packer
// Packs per-point ground/obstacle flags into fixed-width words, buffers the
// words in a show-ahead FIFO drained over valid/ready, and publishes per-scan
// ground/obstacle/longest-obstacle-run statistics when a scan closes.
module lidar_result_packer #(
   parameter int PACK_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int LEN_WIDTH  = $clog2(PACK_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  result_valid,
   input  logic                  segmentation_result,
   input  logic                  scan_last,
   output logic [PACK_WIDTH-1:0] out_word,
   output logic [LEN_WIDTH-1:0]  out_len,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  ground_count,
   output logic [CNT_WIDTH-1:0]  obstacle_count,
   output logic [CNT_WIDTH-1:0]  max_obstacle_run,
   output logic                  summary_valid,
   output logic                  overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ACCUM = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(PACK_WIDTH - 1);
   localparam logic [PTR_W:0]       FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
   endfunction

   // ------------------------------------------------------------------
   // Word assembler
   // ------------------------------------------------------------------
   logic [PACK_WIDTH-1:0] asm_word;
   logic [PACK_WIDTH-1:0] asm_merged;
   logic [LEN_WIDTH-1:0]  bit_cnt;
   logic [LEN_WIDTH-1:0]  close_len;
   logic                  word_close;

   // Merge the incoming flag at the current bit position and decide whether the word closes.
   always_comb begin
      asm_merged = asm_word | (PACK_WIDTH'(segmentation_result) << bit_cnt);
      close_len  = bit_cnt + LEN_WIDTH'(1);
      word_close = result_valid && ((bit_cnt == LAST_IDX) || scan_last);
   end

   // Accumulate flags; clear the assembler once its word has been handed to the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_word <= '0;
         bit_cnt  <= '0;
      end else if (result_valid) begin
         if (word_close) begin
            asm_word <= '0;
            bit_cnt  <= '0;
         end else begin
            asm_word <= asm_merged;
            bit_cnt  <= bit_cnt + LEN_WIDTH'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Word FIFO (show-ahead head)
   // ------------------------------------------------------------------
   logic [PACK_WIDTH-1:0] mem_word [FIFO_DEPTH];
   logic [LEN_WIDTH-1:0]  mem_len  [FIFO_DEPTH];
   logic                  mem_last [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        fill;
   logic                  full;
   logic                  pop;
   logic                  push;

   // A full FIFO still takes a push when the head leaves on the same edge;
   // the write slot then equals the slot being vacated.
   always_comb begin
      full      = (fill == FULL_LVL);
      out_valid = (fill != '0);
      pop       = out_valid && out_ready;
      push      = word_close && (!full || pop);
      out_word  = out_valid ? mem_word[rd_ptr] : '0;
      out_len   = out_valid ? mem_len[rd_ptr]  : '0;
      out_last  = out_valid ? mem_last[rd_ptr] : 1'b0;
   end

   // Storage array: written on every accepted push, contents only visible through the head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_word[wr_ptr] <= asm_merged;
         mem_len[wr_ptr]  <= close_len;
         mem_last[wr_ptr] <= scan_last;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fill <= fill + (PTR_W + 1)'(1);
            2'b01:   fill <= fill - (PTR_W + 1)'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Sticky drop indicator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow <= 1'b0;
      else if (word_close && full && !pop)
         overflow <= 1'b1;
   end

   // ------------------------------------------------------------------
   // Scan statistics
   // ------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] ground_w,  ground_nx;
   logic [CNT_WIDTH-1:0] obst_w,    obst_nx;
   logic [CNT_WIDTH-1:0] run_w,     run_nx;
   logic [CNT_WIDTH-1:0] max_w,     max_nx;

   // Working counters as they stand once the current point is included.
   always_comb begin
      ground_nx = segmentation_result ? sat_inc(ground_w) : ground_w;
      obst_nx   = segmentation_result ? obst_w : sat_inc(obst_w);
      run_nx    = segmentation_result ? '0 : sat_inc(run_w);
      max_nx    = (run_nx > max_w) ? run_nx : max_w;
   end

   // Working counters advance per accepted point and restart after the scan's last point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ground_w <= '0;
         obst_w   <= '0;
         run_w    <= '0;
         max_w    <= '0;
      end else if (result_valid) begin
         if (scan_last) begin
            ground_w <= '0;
            obst_w   <= '0;
            run_w    <= '0;
            max_w    <= '0;
         end else begin
            ground_w <= ground_nx;
            obst_w   <= obst_nx;
            run_w    <= run_nx;
            max_w    <= max_nx;
         end
      end
   end

   // Publish the completed scan's totals and pulse summary_valid for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ground_count     <= '0;
         obstacle_count   <= '0;
         max_obstacle_run <= '0;
         summary_valid    <= 1'b0;
      end else begin
         summary_valid <= result_valid && scan_last;
         if (result_valid && scan_last) begin
            ground_count     <= ground_nx;
            obstacle_count   <= obst_nx;
            max_obstacle_run <= max_nx;
         end
      end
   end

   // ------------------------------------------------------------------
   // Scan control state (informational)
   // ------------------------------------------------------------------
   logic [0:0] state;
   logic [0:0] state_nx;

   // IDLE until a point arrives, back to IDLE when the scan's last point is taken.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (result_valid && !scan_last) state_nx = S_ACCUM;
         S_ACCUM: if (result_valid && scan_last)  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

endmodule

// File: tb/tb_lidar_result_packer.sv
// Self-checking bench for lidar_result_packer: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_lidar_result_packer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main DUT (default parameters)
   logic        rv, sr, sl, ordy;
   logic [15:0] ow;
   logic [4:0]  ol;
   logic        olast, ov, sv, ovf;
   logic [15:0] gc, oc, mr;

   // saturation DUT (4-bit counters)
   logic        rv4, sr4, sl4, ordy4;
   logic [15:0] ow4;
   logic [4:0]  ol4;
   logic        olast4, ov4, sv4, ovf4;
   logic [3:0]  gc4, oc4, mr4;

   lidar_result_packer dut (
      .clk(clk), .rst(rst), .result_valid(rv), .segmentation_result(sr), .scan_last(sl),
      .out_word(ow), .out_len(ol), .out_last(olast), .out_valid(ov), .out_ready(ordy),
      .ground_count(gc), .obstacle_count(oc), .max_obstacle_run(mr),
      .summary_valid(sv), .overflow(ovf)
   );

   lidar_result_packer #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .result_valid(rv4), .segmentation_result(sr4), .scan_last(sl4),
      .out_word(ow4), .out_len(ol4), .out_last(olast4), .out_valid(ov4), .out_ready(ordy4),
      .ground_count(gc4), .obstacle_count(oc4), .max_obstacle_run(mr4),
      .summary_valid(sv4), .overflow(ovf4)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] w;
      int          len;
      bit          last;
   } word_t;

   word_t mq[$];
   bit    cur_bits[$];
   bit    scan_flags[$];
   bit    m_ovf;
   bit    m_sv;
   int    m_g, m_o, m_r;

   function automatic int sat16(input int x);
      return (x > 65535) ? 65535 : x;
   endfunction

   task automatic model_reset();
      mq.delete();
      cur_bits.delete();
      scan_flags.delete();
      m_ovf = 1'b0;
      m_sv  = 1'b0;
      m_g   = 0;
      m_o   = 0;
      m_r   = 0;
   endtask

   task automatic model_edge(input bit v, input bit f, input bit l, input bit r);
      word_t nw;
      int    acc, g, o, run, best;
      if (r && mq.size() > 0) void'(mq.pop_front());
      m_sv = 1'b0;
      if (v) begin
         cur_bits.push_back(f);
         scan_flags.push_back(f);
         if (l || cur_bits.size() == 16) begin
            acc = 0;
            for (int i = 0; i < cur_bits.size(); i++)
               acc = acc + int'(cur_bits[i]) * (2 ** i);
            nw.w    = acc[15:0];
            nw.len  = cur_bits.size();
            nw.last = l;
            if (mq.size() < 8) mq.push_back(nw);
            else m_ovf = 1'b1;
            cur_bits.delete();
         end
         if (l) begin
            g = 0; o = 0; run = 0; best = 0;
            foreach (scan_flags[i]) begin
               if (scan_flags[i]) begin
                  g++;
                  run = 0;
               end else begin
                  o++;
                  run++;
                  if (run > best) best = run;
               end
            end
            m_g = sat16(g);
            m_o = sat16(o);
            m_r = sat16(best);
            m_sv = 1'b1;
            scan_flags.delete();
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(ov), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("out_word", 32'(ow), 32'(mq[0].w));
         chk("out_len",  32'(ol), 32'(mq[0].len));
         chk("out_last", 32'(olast), 32'(mq[0].last));
      end
      chk("overflow",       32'(ovf), 32'(m_ovf));
      chk("summary_valid",  32'(sv), 32'(m_sv));
      chk("ground_count",   32'(gc), 32'(m_g));
      chk("obstacle_count", 32'(oc), 32'(m_o));
      chk("max_run",        32'(mr), 32'(m_r));
   endtask

   task automatic cycle(input bit v, input bit f, input bit l, input bit r);
      rv = v; sr = f; sl = l; ordy = r;
      @(posedge clk);
      model_edge(v, f, l, r);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rv = 1'b0; sr = 1'b0; sl = 1'b0; ordy = 1'b0;
      #2;
      chk("rst_out_valid", 32'(ov), 0);
      chk("rst_out_word",  32'(ow), 0);
      chk("rst_out_len",   32'(ol), 0);
      chk("rst_out_last",  32'(olast), 0);
      chk("rst_summary",   32'(sv), 0);
      chk("rst_ground",    32'(gc), 0);
      chk("rst_obstacle",  32'(oc), 0);
      chk("rst_run",       32'(mr), 0);
      chk("rst_overflow",  32'(ovf), 0);
      chk("rst4_out_valid", 32'(ov4), 0);
      chk("rst4_overflow",  32'(ovf4), 0);
      chk("rst4_ground",    32'(gc4), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cycle4(input bit v, input bit f, input bit l, input bit r);
      rv4 = v; sr4 = f; sl4 = l; ordy4 = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      rv = 0; sr = 0; sl = 0; ordy = 0;
      rv4 = 0; sr4 = 0; sl4 = 0; ordy4 = 0;
      model_reset();
      #1;
      do_reset();

      // 6: saturation with 4-bit counters, stalled output holds
      for (int i = 0; i < 20; i++) cycle4(1'b1, 1'b0, i == 19, 1'b0);
      chk("t6_obstacle", 32'(oc4), 15);
      chk("t6_run",      32'(mr4), 15);
      chk("t6_ground",   32'(gc4), 0);
      chk("t6_sv",       32'(sv4), 1);
      chk("t6_valid",    32'(ov4), 1);
      for (int i = 0; i < 3; i++) begin
         cycle4(1'b0, 1'b0, 1'b0, 1'b0);
         chk("t6_hold_word", 32'(ow4), 0);
         chk("t6_hold_len",  32'(ol4), 16);
         chk("t6_hold_last", 32'(olast4), 0);
         chk("t6_sv_drop",   32'(sv4), 0);
         chk("t6_obst_hold", 32'(oc4), 15);
      end
      cycle4(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_w2_len",  32'(ol4), 4);
      chk("t6_w2_last", 32'(olast4), 1);
      cycle4(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_empty",    32'(ov4), 0);
      chk("t6_overflow", 32'(ovf4), 0);
      ordy4 = 1'b0;

      // 1: single full ground scan
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, i == 15, 1'b1);
      chk("t1_word", 32'(ow), 32'h0000FFFF);
      chk("t1_len",  32'(ol), 16);
      chk("t1_last", 32'(olast), 1);
      chk("t1_ground", 32'(gc), 16);
      chk("t1_obst",   32'(oc), 0);
      chk("t1_run",    32'(mr), 0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 2: ground / obstacle / ground
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, (i < 15) || (i >= 25), i == 39, 1'b1);
         if (i == 15) begin
            chk("t2_w0", 32'(ow), 32'h7FFF); chk("t2_l0", 32'(ol), 16); chk("t2_e0", 32'(olast), 0);
         end
         if (i == 31) begin
            chk("t2_w1", 32'(ow), 32'hFE00); chk("t2_l1", 32'(ol), 16); chk("t2_e1", 32'(olast), 0);
         end
         if (i == 39) begin
            chk("t2_w2", 32'(ow), 32'h00FF); chk("t2_l2", 32'(ol), 8); chk("t2_e2", 32'(olast), 1);
         end
      end
      chk("t2_ground", 32'(gc), 30);
      chk("t2_obst",   32'(oc), 10);
      chk("t2_run",    32'(mr), 10);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 3: overflow, then drain
      do_reset();
      for (int i = 0; i < 9 * 16; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
      chk("t3_overflow", 32'(ovf), 1);
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_drained", 32'(ov), 0);
      chk("t3_sticky",  32'(ovf), 1);

      // 4: push and pop together while full
      do_reset();
      for (int i = 0; i < 8 * 16 + 15; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t4_no_overflow", 32'(ovf), 0);
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_drained", 32'(ov), 0);

      // 5: reset mid-scan
      do_reset();
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, i == 15, 1'b1);
      chk("t5_word",   32'(ow), 32'h0000FFFF);
      chk("t5_len",    32'(ol), 16);
      chk("t5_last",   32'(olast), 1);
      chk("t5_ground", 32'(gc), 16);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_single", 32'(ov), 0);

      // random traffic, including scan_last without result_valid
      do_reset();
      for (int i = 0; i < 1500; i++)
         cycle(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 9) < 6));
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lidar_result_packer.md
# lidar_result_packer

Consumer for the ground-segmentation output stream. It samples the per-point `segmentation_result` / `result_valid` pair, packs the flags into fixed-width words and buffers them in a FIFO drained over a valid/ready interface. It also produces per-scan statistics: ground count, obstacle count and longest consecutive obstacle run. It sits directly downstream of `lidar_ground_segmentation_top` and feeds the map/host link.

## Interface
- `PACK_WIDTH`, 16: flags per packed word.
- `FIFO_DEPTH`, 8: word FIFO entries; power of two, ≥2.
- `CNT_WIDTH`, 16: width of the statistics counters.
- `LEN_WIDTH`, $clog2(PACK_WIDTH+1): width of `out_len`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `result_valid`  in  1  point flag valid this cycle.
- `segmentation_result`  in  1  1 = ground, 0 = obstacle; sampled only with `result_valid`.
- `scan_last`  in  1  marks the last point of a scan; sampled only with `result_valid`.
- `out_word`  out  PACK_WIDTH  packed flags; bit i = i-th point of the word, LSB first.
- `out_len`  out  LEN_WIDTH  number of valid bits in `out_word` (1..PACK_WIDTH).
- `out_last`  out  1  word closes a scan.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head.
- `ground_count`  out  CNT_WIDTH  ground points in the last completed scan.
- `obstacle_count`  out  CNT_WIDTH  obstacle points in the last completed scan.
- `max_obstacle_run`  out  CNT_WIDTH  longest consecutive obstacle run in the last completed scan.
- `summary_valid`  out  1  one-cycle pulse when the summary outputs update.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
- **Accept.** A point is accepted on any rising edge with `result_valid`=1. The flag goes into the assembler at bit index `bit_cnt`, and `bit_cnt` increments.
- **Word close.** A word closes when the accepted point makes `bit_cnt` = PACK_WIDTH, or when `scan_last`=1.
  - Closing pushes {word, len = bit_cnt+1, last = scan_last} into the FIFO.
  - The assembler and `bit_cnt` clear.
  - Unused high bits of a partial word are 0.
- **Full FIFO.** A push into a full FIFO with no simultaneous pop drops the word and sets `overflow`. `overflow` stays set until `rst`.
- **Simultaneous push and pop.** Push and pop in the same edge are both performed, including when the FIFO is full (no overflow) and when it is empty (pop is ignored, push succeeds).
- **Output hold.** Pop happens on an edge with `out_valid`=1 and `out_ready`=1. While `out_valid`=1 and `out_ready`=0, `out_word`/`out_len`/`out_last` hold stable.
- **Working counters.** Ground, obstacle, current-run and max-run counters all saturate at 2^CNT_WIDTH−1.
  - An obstacle increments the current run.
  - A ground point clears the current run.
  - Max-run = max(max-run, updated current run), including the accepted point.
- **Scan close.** On the point with `scan_last`=1:
  - Working counters (including that point) are copied to the summary outputs.
  - `summary_valid` pulses.
  - Working counters clear for the next scan.
- **Control state.** Scan state is IDLE → ACCUM on the first accepted point, and ACCUM → IDLE on `scan_last`. The state is informational only; accept behaviour is identical in both states.

## Timing
- **Reset values.** All outputs are 0: `out_valid`, `out_word`, `out_len`, `out_last`, `summary_valid`, counts, `overflow`. The FIFO is empty and the assembler is cleared.
- **Reset mid-operation.** `rst` asserted mid-scan discards the partial word, FIFO contents and working counters. The next accepted point is bit 0 of a new scan.
- **Word latency.** A word closed at edge E has `out_valid`=1 in the cycle after E, provided the FIFO was empty (show-ahead head).
- **Summary latency.** Summary outputs and the `summary_valid` pulse appear in the cycle after the `scan_last` edge. Summary values then hold until the next scan closes.
- **Throughput.** One point per cycle sustained. One word pops per cycle.
- **`scan_last` without valid.** `scan_last` with `result_valid`=0 has no effect.

## Test plan
1. **Single full ground scan.** 16 ground points, `scan_last` on the 16th, `out_ready`=1.
   - One word: 0xFFFF, len 16, last=1.
   - Summary: ground 16, obstacle 0, run 0.
2. **Ground / obstacle / ground.** 15 ground, then 10 obstacle, then 15 ground; `scan_last` on point 40.
   - Words: 0x7FFF/16/0, then 0xFE00/16/0, then 0x00FF/8/1.
   - Summary: ground 30, obstacle 10, max run 10.
3. **Overflow.** `out_ready`=0, push 9 full words.
   - `overflow`=1 and the 9th word is dropped.
   - Then `out_ready`=1: exactly 8 words drain in push order, `out_valid` falls after the 8th, and `overflow` stays 1.
4. **Push and pop when full.** FIFO full, then a push and pop in the same edge.
   - No overflow; occupancy stays 8; the new word appears as the last one drained.
5. **Reset mid-scan.** 7 points accepted, then `rst` pulsed, then 16 ground points with `scan_last`.
   - Only 0xFFFF/16/1 is output; summary ground 16.
6. **Saturation and hold.** `CNT_WIDTH`=4, 20 obstacle points with `scan_last` on the last, `out_ready` held 0 for 3 cycles.
   - obstacle_count 15, max run 15.
   - `out_word` is stable while stalled.
